// File: rtl/alu_pkg.sv
// Shared constants and types for the EX-stage ALU control and its multiply/divide sequencer.
// Holds the ALU control codes, ALUOp/funct encodings, mul/div op type and FSM states.
package alu_pkg;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_NOR  = 4'b0100;
    localparam logic [3:0] CTRL_SLL  = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SRL  = 4'b1000;
    localparam logic [3:0] CTRL_SRA  = 4'b1001;
    localparam logic [3:0] CTRL_SLTU = 4'b1010;
    localparam logic [3:0] CTRL_ADDU = 4'b1011;
    localparam logic [3:0] CTRL_SUBU = 4'b1100;
    localparam logic [3:0] CTRL_PASS = 4'b1111;

    localparam logic [2:0] ALUOP_AND   = 3'b000;
    localparam logic [2:0] ALUOP_OR    = 3'b001;
    localparam logic [2:0] ALUOP_ADD   = 3'b010;
    localparam logic [2:0] ALUOP_SUB   = 3'b011;
    localparam logic [2:0] ALUOP_RTYPE = 3'b100;
    localparam logic [2:0] ALUOP_XOR   = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;
    localparam logic [2:0] ALUOP_SLTU  = 3'b111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/alu_control_mc_if.sv
// EX-stage bus between the pipeline (master) and the ALU control block (slave).
interface alu_control_mc_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 3,
    parameter int CTRL_WIDTH  = 4
);
    logic                   Valid__i;
    logic [ALUOP_WIDTH-1:0] ALUOp__i;
    logic [5:0]             ALUFunction__i;
    logic [DATA_WIDTH-1:0]  OperandA__i;
    logic [DATA_WIDTH-1:0]  OperandB__i;
    logic [CTRL_WIDTH-1:0]  ALUCtrl__o;
    logic                   Stall__o;
    logic [DATA_WIDTH-1:0]  HiLoData__o;
    logic                   HiLoValid__o;
    logic                   DivByZero__o;

    modport master (
        output Valid__i, ALUOp__i, ALUFunction__i, OperandA__i, OperandB__i,
        input  ALUCtrl__o, Stall__o, HiLoData__o, HiLoValid__o, DivByZero__o
    );

    modport slave (
        input  Valid__i, ALUOp__i, ALUFunction__i, OperandA__i, OperandB__i,
        output ALUCtrl__o, Stall__o, HiLoData__o, HiLoValid__o, DivByZero__o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) / restoring divide datapath working on operand magnitudes.
// res_hi/res_lo present the sign-corrected result of the step taken in the cycle where last is high.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  md_op_t                op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] res_hi,
    output logic [DATA_WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] a_mag_reg, b_mag_reg, acc_reg, low_reg;
    logic [CW-1:0]         cnt_reg;
    logic                  is_div_reg, neg_res_reg, neg_rem_reg;

    logic                  is_signed, is_div;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        a_mag     = (is_signed && a[DATA_WIDTH-1]) ? -a : a;
        b_mag     = (is_signed && b[DATA_WIDTH-1]) ? -b : b;
    end

    logic [DATA_WIDTH:0]     sum, shifted, diff;
    logic                    ge;
    logic [DATA_WIDTH-1:0]   acc_next, low_next;
    logic [2*DATA_WIDTH-1:0] prod;

    // Multiply keeps {acc,low} as the partial product with the multiplier shifting out of low;
    // divide keeps acc as the partial remainder and shifts quotient bits into low.
    always_comb begin
        sum     = {1'b0, acc_reg} + (low_reg[0] ? {1'b0, a_mag_reg} : '0);
        shifted = {acc_reg, low_reg[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, b_mag_reg};
        ge      = ~diff[DATA_WIDTH];
        if (is_div_reg) begin
            acc_next = ge ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
            low_next = {low_reg[DATA_WIDTH-2:0], ge};
        end else begin
            acc_next = sum[DATA_WIDTH:1];
            low_next = {sum[0], low_reg[DATA_WIDTH-1:1]};
        end
        prod = {acc_next, low_next};
        if (is_div_reg) begin
            res_lo = neg_res_reg ? -low_next : low_next;
            res_hi = neg_rem_reg ? -acc_next : acc_next;
        end else begin
            if (neg_res_reg) prod = -prod;
            res_hi = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            res_lo = prod[DATA_WIDTH-1:0];
        end
    end

    assign last = (cnt_reg == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_mag_reg   <= '0;
            b_mag_reg   <= '0;
            acc_reg     <= '0;
            low_reg     <= '0;
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
        end else if (load) begin
            a_mag_reg   <= a_mag;
            b_mag_reg   <= b_mag;
            acc_reg     <= '0;
            low_reg     <= is_div ? a_mag : b_mag;
            cnt_reg     <= CW'(DATA_WIDTH);
            is_div_reg  <= is_div;
            neg_res_reg <= is_signed && (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
            neg_rem_reg <= is_signed && is_div && a[DATA_WIDTH-1];
        end else if (step) begin
            acc_reg <= acc_next;
            low_reg <= low_next;
            cnt_reg <= cnt_reg - CW'(1);
        end
    end
endmodule

// File: rtl/alu_control_mc.sv
// EX-stage ALU control: funct/ALUOp decode, mul/div sequencing FSM, HI/LO registers and stall.
// The iterative arithmetic itself lives in muldiv_iter.
module alu_control_mc
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 3,
    parameter int CTRL_WIDTH  = 4
) (
    input  logic              clock__i,
    input  logic              reset_n__i,
    alu_control_mc_if.slave   bus
);
    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] hi_reg, lo_reg;
    logic                  dbz_reg;

    logic                  is_rtype, start, div0, last;
    logic [3:0]            ctrl;
    md_op_t                md_op;
    logic [DATA_WIDTH-1:0] res_hi, res_lo;

    assign is_rtype = (bus.ALUOp__i == ALUOP_WIDTH'(ALUOP_RTYPE));

    always_comb begin
        ctrl = CTRL_SUB;
        case (bus.ALUOp__i)
            ALUOP_WIDTH'(ALUOP_AND):  ctrl = CTRL_AND;
            ALUOP_WIDTH'(ALUOP_OR):   ctrl = CTRL_OR;
            ALUOP_WIDTH'(ALUOP_ADD):  ctrl = CTRL_ADD;
            ALUOP_WIDTH'(ALUOP_SUB):  ctrl = CTRL_SUB;
            ALUOP_WIDTH'(ALUOP_XOR):  ctrl = CTRL_XOR;
            ALUOP_WIDTH'(ALUOP_SLT):  ctrl = CTRL_SLT;
            ALUOP_WIDTH'(ALUOP_SLTU): ctrl = CTRL_SLTU;
            ALUOP_WIDTH'(ALUOP_RTYPE): begin
                case (bus.ALUFunction__i)
                    FN_ADD:   ctrl = CTRL_ADD;
                    FN_ADDU:  ctrl = CTRL_ADDU;
                    FN_SUB:   ctrl = CTRL_SUB;
                    FN_SUBU:  ctrl = CTRL_SUBU;
                    FN_AND:   ctrl = CTRL_AND;
                    FN_OR:    ctrl = CTRL_OR;
                    FN_XOR:   ctrl = CTRL_XOR;
                    FN_NOR:   ctrl = CTRL_NOR;
                    FN_SLT:   ctrl = CTRL_SLT;
                    FN_SLTU:  ctrl = CTRL_SLTU;
                    FN_SLL:   ctrl = CTRL_SLL;
                    FN_SRL:   ctrl = CTRL_SRL;
                    FN_SRA:   ctrl = CTRL_SRA;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                    FN_MFHI, FN_MFLO: ctrl = CTRL_PASS;
                    default:  ctrl = CTRL_SUB;
                endcase
            end
            default: ctrl = CTRL_SUB;
        endcase
    end

    assign bus.ALUCtrl__o = CTRL_WIDTH'(ctrl);

    always_comb begin
        md_op = OP_MULT;
        case (bus.ALUFunction__i)
            FN_MULTU: md_op = OP_MULTU;
            FN_DIV:   md_op = OP_DIV;
            FN_DIVU:  md_op = OP_DIVU;
            default:  md_op = OP_MULT;
        endcase
    end

    assign start = (state_reg == ST_IDLE) && bus.Valid__i && is_rtype
                   && is_muldiv(bus.ALUFunction__i);
    assign div0  = start && ((md_op == OP_DIV) || (md_op == OP_DIVU))
                   && (bus.OperandB__i == '0);

    muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .clk    (clock__i),
        .rst_n  (reset_n__i),
        .load   (start && !div0),
        .step   (state_reg == ST_BUSY),
        .op     (md_op),
        .a      (bus.OperandA__i),
        .b      (bus.OperandB__i),
        .last   (last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clock__i) begin
        if (!reset_n__i) state_reg <= ST_IDLE;
        else             state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = div0 ? ST_DONE : ST_BUSY;
            ST_BUSY: if (last)  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Divide by zero bypasses the iteration: HI takes the dividend, LO all ones.
    always_ff @(posedge clock__i) begin
        if (!reset_n__i) begin
            hi_reg  <= '0;
            lo_reg  <= '0;
            dbz_reg <= 1'b0;
        end else begin
            if (start) dbz_reg <= div0;
            if (div0) begin
                hi_reg <= bus.OperandA__i;
                lo_reg <= '1;
            end else if ((state_reg == ST_BUSY) && last) begin
                hi_reg <= res_hi;
                lo_reg <= res_lo;
            end
        end
    end

    assign bus.Stall__o     = start || (state_reg == ST_BUSY);
    assign bus.DivByZero__o = (state_reg == ST_DONE) && dbz_reg;
    assign bus.HiLoData__o  = (is_rtype && (bus.ALUFunction__i == FN_MFHI)) ? hi_reg : lo_reg;
    assign bus.HiLoValid__o = bus.Valid__i && is_rtype
                              && ((bus.ALUFunction__i == FN_MFHI) || (bus.ALUFunction__i == FN_MFLO));
endmodule
